// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache between the memory stage and data memory.
// Memory handshake: MEM_REQ/MEM_WE/MEM_ADDR/MEM_WDATA hold steady until the one-cycle MEM_ACK; MEM_ACK with MEM_REQ low is ignored.
module dcache_ctrl #(
  parameter int NLINES = 8,
  parameter int WORDS  = 4,
  parameter int AW     = 12
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          MemLD,
  input  logic          MemWE,
  input  logic [AW-1:0] ADDR,
  input  logic [31:0]   WDATA,
  output logic [31:0]   RDATA,
  output logic          stall,
  output logic          MEM_REQ,
  output logic          MEM_WE,
  output logic [AW-1:0] MEM_ADDR,
  output logic [31:0]   MEM_WDATA,
  input  logic [31:0]   MEM_RDATA,
  input  logic          MEM_ACK,
  output logic [31:0]   HITS,
  output logic [31:0]   MISSES,
  output logic [1:0]    dbg_state
);

  localparam int OW = $clog2(WORDS);
  localparam int IW = $clog2(NLINES);
  localparam int TW = AW - OW - IW - 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [31:0]       data_arr [NLINES][WORDS];
  logic [TW-1:0]     tag_arr  [NLINES];
  logic [NLINES-1:0] valid;
  logic [OW-1:0]     cnt;
  logic              refill_flag;

  logic [OW-1:0] offset;
  logic [IW-1:0] index;
  logic [TW-1:0] tag;
  logic [IW-1:0] fill_idx;
  logic [TW-1:0] fill_tag;
  logic          hit;
  logic          ack;
  logic          fill_last;
  logic          ld_hit;
  logic          ld_miss;
  logic          st_req;

  assign offset    = ADDR[OW+1:2];
  assign index     = ADDR[OW+IW+1:OW+2];
  assign tag       = ADDR[AW-1:OW+IW+2];
  // During a refill the line being filled is identified by the outstanding memory address.
  assign fill_idx  = MEM_ADDR[OW+IW+1:OW+2];
  assign fill_tag  = MEM_ADDR[AW-1:OW+IW+2];
  assign hit       = valid[index] && (tag_arr[index] == tag);
  assign ack       = MEM_ACK && MEM_REQ;
  assign fill_last = (cnt == OW'(WORDS - 1));
  assign dbg_state = state;

  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    RDATA    = '0;
    ld_hit   = 1'b0;
    ld_miss  = 1'b0;
    st_req   = 1'b0;
    if (!RST) begin
      case (state)
        IDLE: begin
          if (MemWE) begin
            stall    = 1'b1;
            st_req   = 1'b1;
            state_nx = WRITE;
          end else if (MemLD) begin
            if (hit) begin
              RDATA  = data_arr[index][offset];
              ld_hit = 1'b1;
            end else begin
              stall    = 1'b1;
              ld_miss  = 1'b1;
              state_nx = FILL;
            end
          end
        end
        FILL: begin
          stall = 1'b1;
          if (ack && fill_last) state_nx = IDLE;
        end
        WRITE: begin
          stall = !MEM_ACK;
          if (ack) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid       <= '0;
      MEM_REQ     <= 1'b0;
      MEM_WE      <= 1'b0;
      MEM_ADDR    <= '0;
      MEM_WDATA   <= '0;
      HITS        <= '0;
      MISSES      <= '0;
      refill_flag <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (st_req) begin
            MEM_REQ   <= 1'b1;
            MEM_WE    <= 1'b1;
            MEM_ADDR  <= {ADDR[AW-1:2], 2'b00};
            MEM_WDATA <= WDATA;
          end else if (ld_hit) begin
            // The first hit after a refill is the replayed miss, already counted.
            if (!refill_flag) HITS <= HITS + 32'd1;
            refill_flag <= 1'b0;
          end else if (ld_miss) begin
            MISSES   <= MISSES + 32'd1;
            MEM_REQ  <= 1'b1;
            MEM_WE   <= 1'b0;
            MEM_ADDR <= {ADDR[AW-1:OW+2], {(OW+2){1'b0}}};
            cnt      <= '0;
          end
        end
        FILL: begin
          if (ack) begin
            cnt      <= cnt + OW'(1);
            MEM_ADDR <= MEM_ADDR + AW'(4);
            if (fill_last) begin
              valid[fill_idx] <= 1'b1;
              MEM_REQ         <= 1'b0;
              refill_flag     <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (ack) begin
            MEM_REQ <= 1'b0;
            MEM_WE  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage arrays carry no reset; the valid bits alone decide what is usable.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (st_req && hit) data_arr[index][offset] <= WDATA;
      if (state == FILL && ack) begin
        data_arr[fill_idx][cnt] <= MEM_RDATA;
        if (fill_last) tag_arr[fill_idx] <= fill_tag;
      end
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: responsive memory model, transaction scoreboard and counter checks.
module tb_dcache_ctrl;

  localparam int TXW = 45;

  logic        CLK;
  logic        RST;
  logic        MemLD;
  logic        MemWE;
  logic [11:0] ADDR;
  logic [31:0] WDATA;
  logic [31:0] RDATA;
  logic        stall;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [11:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic [31:0] MEM_RDATA;
  logic        MEM_ACK;
  logic [31:0] HITS;
  logic [31:0] MISSES;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [TXW-1:0] exp_q[$];
  logic [TXW-1:0] act_q[$];
  logic [31:0]    mem_wr [int];
  int             wait_cnt;

  dcache_ctrl #(.NLINES(8), .WORDS(4), .AW(12)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .MemLD     (MemLD),
    .MemWE     (MemWE),
    .ADDR      (ADDR),
    .WDATA     (WDATA),
    .RDATA     (RDATA),
    .stall     (stall),
    .MEM_REQ   (MEM_REQ),
    .MEM_WE    (MEM_WE),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_WDATA (MEM_WDATA),
    .MEM_RDATA (MEM_RDATA),
    .MEM_ACK   (MEM_ACK),
    .HITS      (HITS),
    .MISSES    (MISSES),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [11:0] a);
    if (mem_wr.exists(int'(a))) return mem_wr[int'(a)];
    return 32'h5A5A0000 ^ {20'h0, a};
  endfunction

  // Memory model: acknowledges the second negedge that sees a request pending.
  initial begin
    MEM_ACK   = 1'b0;
    MEM_RDATA = '0;
    wait_cnt  = 0;
    forever begin
      @(negedge CLK);
      if (MEM_ACK) begin
        MEM_ACK   = 1'b0;
        MEM_RDATA = '0;
        wait_cnt  = 0;
      end else if (MEM_REQ === 1'b1 && RST === 1'b0) begin
        wait_cnt++;
        if (wait_cnt == 2) begin
          MEM_ACK  = 1'b1;
          wait_cnt = 0;
          if (MEM_WE) begin
            mem_wr[int'(MEM_ADDR)] = MEM_WDATA;
            act_q.push_back({1'b1, MEM_ADDR, MEM_WDATA});
          end else begin
            MEM_RDATA = mem_rd(MEM_ADDR);
            act_q.push_back({1'b0, MEM_ADDR, 32'h0});
          end
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Driver tasks
  task automatic push_read_line(input logic [11:0] base);
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, base + 12'(4 * i), 32'h0});
  endtask

  task automatic check_tx();
    while (exp_q.size() > 0) begin
      if (act_q.size() == 0) check("tx_missing", 64'h0, 64'(exp_q.pop_front()));
      else check("tx", 64'(act_q.pop_front()), 64'(exp_q.pop_front()));
    end
    check("tx_extra", 64'(act_q.size()), 64'h0);
    act_q.delete();
  endtask

  task automatic do_load(input logic [11:0] a, input logic exp_stall, input logic [31:0] exp_data);
    int cyc;
    @(negedge CLK);
    ADDR = a; MemLD = 1'b1; MemWE = 1'b0;
    #1;
    check("ld_stall", 64'(stall), 64'(exp_stall));
    cyc = 0;
    while (stall && cyc < 200) begin
      @(negedge CLK); #1; cyc++;
    end
    check("ld_done", 64'(stall), 64'h0);
    check("ld_rdata", 64'(RDATA), 64'(exp_data));
    @(posedge CLK); #1;
    MemLD = 1'b0;
  endtask

  task automatic do_store(input logic [11:0] a, input logic [31:0] d);
    int cyc;
    @(negedge CLK);
    ADDR = a; WDATA = d; MemWE = 1'b1; MemLD = 1'b0;
    #1;
    check("st_stall", 64'(stall), 64'h1);
    cyc = 0;
    while (stall && cyc < 200) begin
      @(negedge CLK); #1; cyc++;
    end
    check("st_done", 64'(stall), 64'h0);
    check("st_ack", 64'(MEM_ACK), 64'h1);
    @(posedge CLK); #1;
    MemWE = 1'b0;
    check("st_req_drop", 64'(MEM_REQ), 64'h0);
  endtask

  task automatic check_counters(input logic [31:0] h, input logic [31:0] m);
    check("hits", 64'(HITS), 64'(h));
    check("misses", 64'(MISSES), 64'(m));
  endtask

  initial begin
    int cyc;
    RST = 1'b1; MemLD = 1'b1; MemWE = 1'b0; ADDR = 12'h040; WDATA = '0;

    // Reset: outputs quiet even with a load pending
    repeat (2) @(posedge CLK);
    #1;
    check("rst_stall", 64'(stall), 64'h0);
    check("rst_rdata", 64'(RDATA), 64'h0);
    check("rst_req", 64'(MEM_REQ), 64'h0);
    check("rst_we", 64'(MEM_WE), 64'h0);
    check("rst_addr", 64'(MEM_ADDR), 64'h0);
    check("rst_wdata", 64'(MEM_WDATA), 64'h0);
    check("rst_state", 64'(dbg_state), 64'h0);
    check_counters(32'd0, 32'd0);
    MemLD = 1'b0;
    @(negedge CLK);
    RST = 1'b0;

    // 1: cold miss refills the line
    push_read_line(12'h040);
    do_load(12'h040, 1'b1, 32'h5A5A0040);
    check_tx();
    check_counters(32'd0, 32'd1);

    // 2: hit in same cycle, no memory traffic
    do_load(12'h048, 1'b0, 32'h5A5A0048);
    check("hit_no_req", 64'(MEM_REQ), 64'h0);
    check_tx();
    check_counters(32'd1, 32'd1);

    // 3: write hit goes through and updates the line
    exp_q.push_back({1'b1, 12'h044, 32'hDEADBEEF});
    do_store(12'h044, 32'hDEADBEEF);
    check_tx();
    do_load(12'h044, 1'b0, 32'hDEADBEEF);
    check_counters(32'd2, 32'd1);

    // 4: conflicting tag evicts, original line refetched from memory
    push_read_line(12'h0C0);
    do_load(12'h0C0, 1'b1, 32'h5A5A00C0);
    check_tx();
    check_counters(32'd2, 32'd2);
    push_read_line(12'h040);
    do_load(12'h040, 1'b1, 32'h5A5A0040);
    check_tx();
    check_counters(32'd2, 32'd3);
    do_load(12'h044, 1'b0, 32'hDEADBEEF);
    check_counters(32'd3, 32'd3);

    // 5: write miss does not allocate
    exp_q.push_back({1'b1, 12'h200, 32'h12345678});
    do_store(12'h200, 32'h12345678);
    check_tx();
    push_read_line(12'h200);
    do_load(12'h200, 1'b1, 32'h12345678);
    check_tx();
    check_counters(32'd3, 32'd4);

    // 6: reset in the middle of a refill
    exp_q.push_back({1'b0, 12'h0C0, 32'h0});
    exp_q.push_back({1'b0, 12'h0C4, 32'h0});
    @(negedge CLK);
    ADDR = 12'h0C0; MemLD = 1'b1;
    cyc = 0;
    do begin
      @(negedge CLK); #1; cyc++;
    end while (!(act_q.size() >= 2 && MEM_ACK) && cyc < 200);
    check("rst_wait", 64'(act_q.size() >= 2 && MEM_ACK), 64'h1);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    check("mid_rst_req", 64'(MEM_REQ), 64'h0);
    check("mid_rst_stall", 64'(stall), 64'h0);
    check("mid_rst_rdata", 64'(RDATA), 64'h0);
    check("mid_rst_state", 64'(dbg_state), 64'h0);
    check_counters(32'd0, 32'd0);
    MemLD = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    check_tx();
    push_read_line(12'h040);
    do_load(12'h040, 1'b1, 32'h5A5A0040);
    check_tx();
    check_counters(32'd0, 32'd1);
    do_load(12'h04C, 1'b0, 32'h5A5A004C);
    do_load(12'h0C8, 1'b1, 32'h5A5A00C8);
    exp_q.delete();
    act_q.delete();
    check_counters(32'd1, 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
